key_filter: RTL
===============

KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter DEB_CYCLES, default 4000, sets the debounce window in clk cycles (20 ms at 200 kHz); legal range 2..8191.
REQ-002 The port list SHALL be: clk  input  1  system clock (200 kHz); rising edge active.
REQ-003 The port list SHALL be: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 The port list SHALL be: key_os_n  input  1  raw OS sensor contact; asynchronous to clk; low = pressed.
REQ-005 The port list SHALL be: key_key_n  input  1  raw ON/OFF push-button; asynchronous to clk; low = pressed.
REQ-006 The port list SHALL be: flag_os  output  1  OS channel filter busy; high while a level change is being qualified.
REQ-007 The port list SHALL be: stable_os  output  1  OS channel one-cycle pulse on a qualified press.
REQ-008 The port list SHALL be: flag_key  output  1  KEY channel filter busy.
REQ-009 The port list SHALL be: stable_key  output  1  KEY channel one-cycle pulse on a qualified press.

Function
REQ-010 Each channel SHALL be an identical, fully independent instance of the behaviour in REQ-011..REQ-020; no shared counters or state.
REQ-011 The raw input SHALL pass through a 2-flop synchronizer (reset value 1) before any other logic; only the synchronized level (sync) is used downstream.
REQ-012 The per-channel FSM SHALL have states UP (settled released), PRESS_FILT, DOWN (settled pressed), REL_FILT; the reset state is UP.
REQ-013 UP -> PRESS_FILT when sync = 0; counter cleared to 0.
REQ-014 In PRESS_FILT:
- counter increments by 1 each cycle while sync = 0;
- sync = 1 returns to UP with the counter cleared (bounce rejected, no pulse);
- when the counter reaches DEB_CYCLES-1 with sync = 0, go to DOWN.
REQ-015 DOWN -> REL_FILT when sync = 1; counter cleared.
REQ-016 In REL_FILT:
- counter increments while sync = 1;
- sync = 0 returns to DOWN with the counter cleared;
- when the counter reaches DEB_CYCLES-1 with sync = 1, go to UP.
REQ-017 The counter SHALL be 13 bits wide, SHALL saturate-free count only inside a filter state, and SHALL hold 0 in UP and DOWN; it never wraps within the legal DEB_CYCLES range.
REQ-018 flag_x SHALL be registered and SHALL be 1 exactly in the cycles the FSM is in PRESS_FILT or REL_FILT; 0 otherwise.
REQ-019 stable_x SHALL be registered and high for exactly one clk cycle, coincident with the first cycle the FSM is in DOWN; release SHALL generate no pulse.
REQ-020 Latency: for a clean press (raw low held, no bounce), stable_x SHALL assert DEB_CYCLES+3 clock edges after the first edge that samples the raw input low. flag_x SHALL rise 3 edges after that edge.
REQ-021 A bounce of any length shorter than DEB_CYCLES in a filter state SHALL produce no stable_x pulse and restarts qualification from 0 on the next change.
REQ-022 A key held through a full press SHALL produce exactly one pulse regardless of hold duration; a new pulse requires a qualified release first.
REQ-023 Simultaneous activity on both channels SHALL be handled concurrently; both stable pulses may assert in the same cycle.

Reset
REQ-024 On rst_n low, all outputs SHALL be 0 immediately (asynchronous); synchronizers go to 1, FSMs to UP, counters to 0.
REQ-025 Reset asserted mid-filter or in DOWN SHALL abort without any pulse. A key still held low after reset release SHALL be qualified as a new press and SHALL pulse after the REQ-020 latency.

Verification (DEB_CYCLES = 8)
REQ-026 Clean press: key_key_n 1->0 held 20 cycles -> flag_key high from edge 3 to 10, stable_key one pulse at edge 11, flag_os/stable_os stay 0.
REQ-027 Bounce: key_os_n low 5 cycles, high 2, low 20 -> no pulse during the first burst; exactly one stable_os pulse 11 edges after the second falling sample.
REQ-028 Release bounce: after a qualified press, key_key_n toggles high/low every 3 cycles for 30 cycles, then held low -> flag_key toggling, zero additional stable_key pulses.
REQ-029 Simultaneous: both raw inputs fall on the same edge, clean -> stable_os and stable_key pulse on the same cycle.
REQ-030 Reset mid-filter: rst_n low at PRESS_FILT count 4 for 2 cycles, raw held low -> outputs 0 during reset; after release one pulse 11 edges after first post-reset sample.

Source files
------------

// File: rtl/key_filter.sv
// Two-channel key debouncer: each raw active-low contact is synchronized, then
// qualified by a four-state filter FSM that emits one pulse per settled press.

module key_filter_chan #(
  parameter int DEB_CYCLES = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic flag,
  output logic stable
);

  typedef enum logic [1:0] {
    UP         = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  localparam logic [12:0] CNT_MAX = 13'(DEB_CYCLES - 1);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic        hit_q, hit_d;
  logic        flag_q, flag_d;
  logic        stable_q, stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= UP;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      flag_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      flag_q   <= flag_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = '0;
    hit_d   = 1'b0;
    case (state_q)
      UP: begin
        if (!sync2_q) state_d = PRESS_FILT;
      end
      PRESS_FILT: begin
        if (sync2_q) begin
          state_d = UP;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DOWN;
          hit_d   = 1'b1;
        end else begin
          cnt_d = 13'(cnt_q + 13'd1);
        end
      end
      DOWN: begin
        if (sync2_q) state_d = REL_FILT;
      end
      REL_FILT: begin
        if (!sync2_q) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_MAX) begin
          state_d = UP;
        end else begin
          cnt_d = 13'(cnt_q + 13'd1);
        end
      end
      default: state_d = UP;
    endcase
    // hit_q marks the first DOWN cycle; outputs trail the FSM by one register
    flag_d   = (state_q == PRESS_FILT) || (state_q == REL_FILT);
    stable_d = hit_q;
  end

  assign flag   = flag_q;
  assign stable = stable_q;

endmodule

module key_filter #(
  parameter int DEB_CYCLES = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_os_n,
  input  logic key_key_n,
  output logic flag_os,
  output logic stable_os,
  output logic flag_key,
  output logic stable_key
);

  key_filter_chan #(.DEB_CYCLES(DEB_CYCLES)) u_os (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_os_n),
    .flag   (flag_os),
    .stable (stable_os)
  );

  key_filter_chan #(.DEB_CYCLES(DEB_CYCLES)) u_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_key_n),
    .flag   (flag_key),
    .stable (stable_key)
  );

endmodule
